rptr_empty_fwft: RTL and testbench
==================================

Name: rptr_empty_fwft

Overview:
- Read-side pointer and empty-flag generator for the dual-clock gray-pointer FIFO; the counterpart of the write-pointer/full block.
- Owns the read binary and gray pointers and drives the memory read address.
- Compares its pointer against the write gray pointer, already synchronised into rclk, to derive empty.
- Adds a one-entry first-word-fall-through (FWFT) output register, a registered occupancy count and an almost-empty flag.

Parameters:
- ADDR_WIDTH, 3, memory address bits; FIFO depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 8, word width.
- AE_THRESH, 1, almost_empty asserts when total words held are less than or equal to this value.

Ports:
- rclk  in  1  read-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- rinc  in  1  consumer pop; only effective when rvalid=1.
- wptr_sync  in  ADDR_WIDTH+1  write gray pointer, two-flop synchronised into rclk.
- mem_rdata  in  DATA_WIDTH  combinational memory read data at raddr.
- raddr  out  ADDR_WIDTH  memory read address, equal to rbin[ADDR_WIDTH-1:0].
- rptr  out  ADDR_WIDTH+1  registered read gray pointer, sent to the write-domain synchroniser.
- rdata  out  DATA_WIDTH  FWFT output word, valid while rvalid=1.
- rvalid  out  1  rdata holds a word.
- empty  out  1  equals ~rvalid.
- almost_empty  out  1  registered.
- rlevel  out  ADDR_WIDTH+1  registered count of words still in memory, range 0..2^ADDR_WIDTH.

Behaviour:
- Reset (async, rst_n=0):
  - rbin=0, rptr=0, core_empty=1.
  - rvalid=0, empty=1, rdata=0, rlevel=0, almost_empty=1.
- Core pointer:
  - mem_pop = ~core_empty & (~rvalid | (rinc & rvalid)).
  - rbin_next = rbin + mem_pop (width ADDR_WIDTH+1, wraps naturally).
  - rgray_next = (rbin_next>>1)^rbin_next.
  - On each rclk edge: rbin<=rbin_next, rptr<=rgray_next, core_empty<=(rgray_next==wptr_sync).
- Output stage states:
  - EMPTY (rvalid=0): if mem_pop, load rdata<=mem_rdata and go to VALID.
  - VALID (rvalid=1), rinc=1 and mem_pop=1: reload rdata<=mem_rdata, stay in VALID (back-to-back, no bubble).
  - VALID, rinc=1 and mem_pop=0: go to EMPTY; rdata holds its stale value.
  - VALID, rinc=0: hold rdata.
- rinc while rvalid=0 is ignored; pointers and state are unchanged.
- Latency:
  - wptr_sync changes before edge N; core_empty falls at edge N; rvalid rises at edge N+1.
  - One cycle of throughput per word when streaming.
- Occupancy:
  - rlevel <= gray2bin(wptr_sync) - rbin_next, computed modulo 2^(ADDR_WIDTH+1).
  - almost_empty <= (rlevel_next + rvalid_next) <= AE_THRESH, computed in ADDR_WIDTH+2 bits.
- Wrap-around: after 2^ADDR_WIDTH pops the MSB of rbin toggles. Empty detection relies on exact gray equality, MSB included.
- A full FIFO (wptr_sync equal to rptr with its two MSBs inverted) reads rlevel=2^ADDR_WIDTH and is not empty.
- Reset mid-stream: all state clears immediately, asynchronously. The write side must be reset together; partial reset is unsupported.
- rlevel and almost_empty are pessimistic (lagging) by the synchroniser latency. They must never report more words than actually exist.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parameterised by width;
  - localparam DEPTH = 1<<ADDR_WIDTH.
  - The write-side block uses the same package.
- One natural sub-module: fifo_out_reg, the FWFT holding register and its EMPTY/VALID state. The pointer core stays in the top module.

Test Plan:
- Reset with wptr_sync=0 -> rptr=0, raddr=0, empty=1, rvalid=0, rlevel=0, almost_empty=1. Hold rinc=1 for 5 cycles -> rptr stays 0.
- Step wptr_sync from gray 0 to gray 1, with mem_rdata=8'hA5 at raddr 0 -> core_empty falls at edge N, rvalid=1 and rdata=8'hA5 at edge N+1, rptr=1, rlevel=0, empty=0.
- Set wptr_sync to gray(8) (FIFO full, ADDR_WIDTH=3) and hold rinc=1 -> eight consecutive words from addresses 0..7, one per cycle, no bubble. Then rvalid=0 and rptr=gray(8)=4'b1100.
- Set wptr_sync=gray(4), rinc=0 -> rvalid=1, rlevel=3, almost_empty=0. Pop 3 words -> almost_empty=1 once rlevel+rvalid is 1 or less (AE_THRESH=1).
- Pointer wrap: pre-advance through 14 writes and reads, then write and read 4 more -> rbin wraps 15 to 0, empty detection stays correct, and data order is preserved.
- Assert rst_n=0 asynchronously mid-stream (rvalid=1, rlevel=5) -> all outputs return to reset values before the next rclk edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared gray/binary helpers and types for the dual-clock FIFO pointer blocks
package fifo_pkg;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int DEPTH = 1 << ADDR_WIDTH_DEF;
  typedef enum logic {ST_EMPTY, ST_VALID} out_state_e;
  // Width-generic: callers zero-extend into 32 bits and size-cast the result back
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b ^= g >> i;
    return b;
  endfunction
endpackage

// File: rtl/rptr_empty_fwft_if.sv
// rptr_empty_fwft_if: consumer handshake, memory read port and pointer exchange of the FIFO read side
interface rptr_empty_fwft_if #(parameter int ADDR_WIDTH = 3, parameter int DATA_WIDTH = 8);
  logic                  rinc;
  logic [ADDR_WIDTH:0]   wptr_sync;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rlevel;
  modport master (output rinc, wptr_sync, mem_rdata,
                  input raddr, rptr, rdata, rvalid, empty, almost_empty, rlevel);
  modport slave (input rinc, wptr_sync, mem_rdata,
                 output raddr, rptr, rdata, rvalid, empty, almost_empty, rlevel);
endinterface

// File: rtl/fifo_out_reg.sv
// fifo_out_reg: one-entry first-word-fall-through holding register with EMPTY/VALID state
module fifo_out_reg
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  rinc,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);
  out_state_e state;
  // load only arrives when empty or when the held word is being consumed
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      rdata <= '0;
    end else if (load) begin
      state <= ST_VALID;
      rdata <= din;
    end else if (state == ST_VALID && rinc) begin
      state <= ST_EMPTY;
    end
  end
  assign rvalid = state == ST_VALID;
endmodule

// File: rtl/rptr_empty_fwft.sv
// rptr_empty_fwft: read pointer, empty detection, occupancy and FWFT output of the dual-clock FIFO
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 1
) (
  input logic             rclk,
  input logic             rst_n,
  rptr_empty_fwft_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int LW = ADDR_WIDTH + 2;
  logic [PW-1:0] rbin, rbin_next, rgray_next, wbin, rlevel_next;
  logic          core_empty, mem_pop, rvalid, rvalid_next, ae_next;
  always_comb begin
    mem_pop     = ~core_empty & (~rvalid | bus.rinc);
    rbin_next   = rbin + PW'(mem_pop);
    rgray_next  = PW'(bin2gray(32'(rbin_next)));
    wbin        = PW'(gray2bin(32'(bus.wptr_sync)));
    rlevel_next = wbin - rbin_next;
    rvalid_next = mem_pop | (rvalid & ~bus.rinc);
    ae_next     = ({1'b0, rlevel_next} + LW'(rvalid_next)) <= LW'(AE_THRESH);
  end
  // Exact gray equality including the MSB keeps a full FIFO from reading as empty
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rbin             <= '0;
      bus.rptr         <= '0;
      core_empty       <= 1'b1;
      bus.rlevel       <= '0;
      bus.almost_empty <= 1'b1;
    end else begin
      rbin             <= rbin_next;
      bus.rptr         <= rgray_next;
      core_empty       <= rgray_next == bus.wptr_sync;
      bus.rlevel       <= rlevel_next;
      bus.almost_empty <= ae_next;
    end
  end
  fifo_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .rclk  (rclk),
    .rst_n (rst_n),
    .load  (mem_pop),
    .rinc  (bus.rinc),
    .din   (bus.mem_rdata),
    .rdata (bus.rdata),
    .rvalid(rvalid)
  );
  assign bus.rvalid = rvalid;
  assign bus.empty  = ~rvalid;
  assign bus.raddr  = rbin[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_rptr_empty_fwft.sv
// tb_rptr_empty_fwft: directed bench with a word scoreboard for the FIFO read side
module tb_rptr_empty_fwft;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int AE = 1;
  logic rclk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] q[$];
  logic [AW:0] wcnt = '0;
  logic [DW-1:0] seed = 8'h30;

  rptr_empty_fwft_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  rptr_empty_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AE_THRESH(AE)) dut (
    .rclk (rclk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 rclk = ~rclk;
  assign bus.mem_rdata = mem[bus.raddr];

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wcnt[AW-1:0]] = d;
    q.push_back(d);
    wcnt++;
    bus.wptr_sync = gray(wcnt);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      push(seed);
      seed++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rptr"}, 32'(bus.rptr), 0);
    check({tag, "_raddr"}, 32'(bus.raddr), 0);
    check({tag, "_empty"}, 32'(bus.empty), 1);
    check({tag, "_rvalid"}, 32'(bus.rvalid), 0);
    check({tag, "_rlevel"}, 32'(bus.rlevel), 0);
    check({tag, "_ae"}, 32'(bus.almost_empty), 1);
    check({tag, "_rdata"}, 32'(bus.rdata), 0);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    bus.rinc = 1'b1;
    while (q.size() > 0 && guard < 64) begin
      if (bus.rvalid) check(tag, 32'(bus.rdata), 32'(q.pop_front()));
      step();
      guard++;
    end
    bus.rinc = 1'b0;
    check({tag, "_left"}, 32'(q.size()), 0);
    step();
    check({tag, "_empty"}, 32'(bus.empty), 1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    bus.rinc = 1'b0;
    bus.wptr_sync = '0;
    repeat (2) step();
    check_reset("rst");
    rst_n = 1'b1;
    bus.rinc = 1'b1;
    repeat (5) step();
    check("idle_rptr", 32'(bus.rptr), 0);
    check("idle_rvalid", 32'(bus.rvalid), 0);
    bus.rinc = 1'b0;

    push(8'hA5);
    step();
    check("lat_n_rvalid", 32'(bus.rvalid), 0);
    check("lat_n_rlevel", 32'(bus.rlevel), 1);
    step();
    check("lat_n1_rvalid", 32'(bus.rvalid), 1);
    check("lat_n1_rdata", 32'(bus.rdata), 32'h A5);
    check("lat_n1_rptr", 32'(bus.rptr), 1);
    check("lat_n1_rlevel", 32'(bus.rlevel), 0);
    check("lat_n1_empty", 32'(bus.empty), 0);
    check("lat_n1_ae", 32'(bus.almost_empty), 1);

    push_n(7);
    step();
    check("fill_rlevel", 32'(bus.rlevel), 7);
    check("fill_ae", 32'(bus.almost_empty), 0);
    bus.rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", 32'(bus.rvalid), 1);
      check("stream_data", 32'(bus.rdata), 32'(q.pop_front()));
      step();
    end
    bus.rinc = 1'b0;
    check("stream_end_rvalid", 32'(bus.rvalid), 0);
    check("stream_end_rptr", 32'(bus.rptr), 32'b1100);
    check("stream_end_raddr", 32'(bus.raddr), 0);

    push_n(8);
    step();
    check("full_rlevel", 32'(bus.rlevel), 8);
    check("full_rvalid", 32'(bus.rvalid), 0);
    step();
    check("full_not_empty", 32'(bus.empty), 0);
    drain("full_drain");

    push_n(4);
    step();
    step();
    check("ae_rvalid", 32'(bus.rvalid), 1);
    check("ae_rlevel", 32'(bus.rlevel), 3);
    check("ae_flag", 32'(bus.almost_empty), 0);
    bus.rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ae_pop_level", 32'(bus.rlevel), 32'(q.size() - 1));
      check("ae_pop_flag", 32'(bus.almost_empty), 32'(q.size() <= AE));
      check("ae_pop_data", 32'(bus.rdata), 32'(q.pop_front()));
      step();
    end
    bus.rinc = 1'b0;
    check("ae_last_flag", 32'(bus.almost_empty), 1);
    check("ae_last_rlevel", 32'(bus.rlevel), 0);
    check("ae_last_rvalid", 32'(bus.rvalid), 1);
    drain("ae_drain");

    push_n(8);
    drain("adv_a");
    push_n(2);
    drain("adv_b");
    push_n(4);
    drain("wrap");
    check("wrap_rptr", 32'(bus.rptr), 32'(gray(wcnt)));
    check("wrap_rlevel", 32'(bus.rlevel), 0);
    repeat (3) step();
    check("wrap_stay_empty", 32'(bus.empty), 1);

    push_n(6);
    step();
    step();
    check("mid_rvalid", 32'(bus.rvalid), 1);
    check("mid_rlevel", 32'(bus.rlevel), 5);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    bus.wptr_sync = '0;
    wcnt = '0;
    q.delete();
    step();
    rst_n = 1'b1;
    push(8'h5A);
    step();
    step();
    check("post_rst_rvalid", 32'(bus.rvalid), 1);
    check("post_rst_rdata", 32'(bus.rdata), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
